// File: rtl/a2d_spi_resp_if.sv
// SPI pin bundle between the A2D SPI master and the emulated converter.
// Ports: SS_n, SCLK, MOSI (master->responder), MISO (responder->master).
interface a2d_spi_resp_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output SS_n,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  SS_n,
        input  SCLK,
        input  MOSI,
        output MISO
    );
endinterface

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D converter.
// Ports: clk, rst (async, active-high), spi (slave modport: SS_n, SCLK,
//   MOSI, MISO), ana_vals[95:0] (ch k at [12k+11:12k]), chnnl_cur,
//   res_cur, frm_done / frm_err (one-cycle frame-end pulses).
module a2d_spi_resp (
    input  logic                 clk,
    input  logic                 rst,
    a2d_spi_resp_if.slave        spi,
    input  logic [95:0]          ana_vals,
    output logic [2:0]           chnnl_cur,
    output logic [11:0]          res_cur,
    output logic                 frm_done,
    output logic                 frm_err
);

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        IDLE    = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [2:0]  ss_q;
    logic [2:0]  sclk_q;
    logic [2:0]  mosi_q;
    logic [1:0]  settle_q;

    logic [15:0] tx_shift;
    logic [15:0] tx_d;
    logic [15:0] rx_shift;
    logic [15:0] rx_d;
    logic [4:0]  bit_cnt;
    logic [4:0]  cnt_d;
    logic [2:0]  chnl_d;
    logic [11:0] res_d;
    logic        done_d;
    logic        err_d;

    logic        ss_s2;
    logic        ss_rise;
    logic        ss_fall;
    logic        sclk_rise;
    logic        sclk_fall;
    logic        mosi_s2;
    logic        settled;
    logic        frm_ok;
    logic [11:0] ana_ch [8];

    // Bit 0 is the first sync stage, bit 1 the usable synced value and
    // bit 2 the history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q   <= 3'b111;
            sclk_q <= 3'b000;
            mosi_q <= 3'b000;
        end else begin
            ss_q   <= {ss_q[1:0], spi.SS_n};
            sclk_q <= {sclk_q[1:0], spi.SCLK};
            mosi_q <= {mosi_q[1:0], spi.MOSI};
        end
    end

    assign ss_s2     = ss_q[1];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign mosi_s2   = mosi_q[1];

    // The SS_n chain still holds its reset value for the first two cycles
    // after reset release; trusting it then would let a frame already in
    // progress slip through WAIT_HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q <= 2'd0;
        end else if (settle_q != 2'd2) begin
            settle_q <= settle_q + 2'd1;
        end
    end

    assign settled = (settle_q == 2'd2);

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            ana_ch[k] = ana_vals[12*k +: 12];
        end
    end

    assign frm_ok = (bit_cnt == 5'd16) &&
                    (rx_shift[15:14] == 2'b00) &&
                    (rx_shift[10:0] == 11'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_HI;
            tx_shift  <= 16'd0;
            rx_shift  <= 16'd0;
            bit_cnt   <= 5'd0;
            chnnl_cur <= 3'd0;
            res_cur   <= 12'd0;
            frm_done  <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_shift  <= tx_d;
            rx_shift  <= rx_d;
            bit_cnt   <= cnt_d;
            chnnl_cur <= chnl_d;
            res_cur   <= res_d;
            frm_done  <= done_d;
            frm_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_shift;
        rx_d    = rx_shift;
        cnt_d   = bit_cnt;
        chnl_d  = chnnl_cur;
        res_d   = res_cur;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            WAIT_HI: begin
                if (settled && ss_s2) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    tx_d    = {4'h0, res_cur};
                    rx_d    = 16'd0;
                    cnt_d   = 5'd0;
                end
            end

            SHIFT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    if (frm_ok) begin
                        chnl_d = rx_shift[13:11];
                        res_d  = ana_ch[rx_shift[13:11]];
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_d = {rx_shift[14:0], mosi_s2};
                        if (bit_cnt != 5'd31) begin
                            cnt_d = bit_cnt + 5'd1;
                        end
                    end
                    // The MSB is presented before the first rise, so the
                    // leading fall (none in mode 0) must not shift it out.
                    if (sclk_fall && (bit_cnt != 5'd0)) begin
                        tx_d = {tx_shift[14:0], 1'b0};
                    end
                end
            end

            default: begin
                state_d = WAIT_HI;
            end
        endcase
    end

    assign spi.MISO = (state_q == SHIFT) ? tx_shift[15] : 1'b0;

endmodule

// File: doc/a2d_spi_resp.md
# a2d_spi_resp

Synthesizable SPI responder modelling the 8-channel, 12-bit A2D converter on the far side of the A2D interface's SPI master. It receives 16-bit command frames on MOSI, decodes the requested channel, samples that channel's value from a flattened input bus, and returns the 12-bit result in the *next* frame on MISO. It sits in the test/emulation fabric in place of the physical converter.

## Interface
- Parameters: none. Frame length is fixed at 16 bits, with 8 channels of 12 bits each.
- clk  input  1  system clock; all logic is on posedge clk.
- rst  input  1  reset, asynchronous, active-high.
- SS_n  input  1  slave select, active-low, asynchronous to clk.
- SCLK  input  1  SPI clock, idle low (mode 0), asynchronous to clk.
- MOSI  input  1  command data from the master.
- ana_vals  input  96  channel values; channel k occupies bits [12k+11:12k].
- MISO  output  1  response data to the master.
- chnnl_cur  output  3  channel latched from the last valid command.
- res_cur  output  12  value sampled for chnnl_cur; this is what the next frame returns.
- frm_done  output  1  one-cycle pulse when a valid frame completes.
- frm_err  output  1  one-cycle pulse when a frame completes malformed.

## Operation
- **Synchronization.** SCLK, SS_n and MOSI each pass through 2 flops, plus a 3rd flop for edge detection.
  - Reset value of the SS_n chain is 1. Reset value of the SCLK and MOSI chains is 0.
  - A rise is `s2 & ~s3`. A fall is `~s2 & s3`.
- **State machine.** States are WAIT_HI, IDLE and SHIFT. Reset enters WAIT_HI.
  - WAIT_HI → IDLE when the synced SS_n is 1. This prevents starting mid-frame if SS_n is low at reset release.
  - IDLE → SHIFT on a synced SS_n fall. On that transition:
    - load tx_shift = {4'h0, res_cur};
    - clear bit_cnt (5 bits, saturating at 31);
    - clear rx_shift (16 bits).
  - SHIFT, on a synced SCLK rise: rx_shift ← {rx_shift[14:0], MOSI_s2}; bit_cnt ← bit_cnt+1 (saturating).
  - SHIFT, on a synced SCLK fall with bit_cnt ≥ 1: tx_shift ← {tx_shift[14:0], 1'b0}. The MSB is therefore valid before the first rise.
  - SHIFT → IDLE on a synced SS_n rise. Frame evaluation happens in the same cycle (see frame completion below).
  - SCLK edges in WAIT_HI or IDLE are ignored.
- **MISO.** Combinational: tx_shift[15] when in SHIFT, otherwise 0.
- **Frame completion**, on the SS_n rise in SHIFT:
  - The frame is valid if bit_cnt == 16, rx_shift[15:14] == 0 and rx_shift[10:0] == 0. On a valid frame:
    - chnnl_cur ← rx_shift[13:11];
    - res_cur ← ana_vals[12·rx_shift[13:11] +: 12];
    - frm_done = 1 for one cycle.
  - Any other frame is malformed: frm_err = 1 for one cycle, and chnnl_cur/res_cur are unchanged.
  - frm_done and frm_err are never asserted together.
- **Sampling.** ana_vals is sampled only at valid frame completion. Later changes to ana_vals do not affect res_cur.
- **Reset values.** MISO, chnnl_cur, res_cur, frm_done and frm_err are all 0. tx_shift, rx_shift and bit_cnt are 0.
- **Reset mid-frame.** The frame is discarded with no pulse. The block waits in WAIT_HI for SS_n high before accepting a frame.

## Timing
- **Clock ratio.** The SCLK high and low phases are each ≥ 4 clk periods. The SS_n setup before the first SCLK rise is ≥ 4 clk.
- **MISO update.** MISO changes 3 clk after a pin-level SCLK fall (2 sync + 1 register), which is within the low phase.
- **MOSI sampling.** MOSI must be stable from the SCLK fall through 3 clk after the SCLK rise.
- **Frame-end latency.** frm_done/frm_err rise 3 clk after the SS_n pin rise. chnnl_cur/res_cur update in the same cycle.
- **Response latency.** The result for channel k is returned one frame after the command selecting k. The first frame after reset returns 0x0000.
- **Back-to-back frames.** A minimum SS_n high time of 4 clk between frames is required.

## Test plan
1. Assert rst, then release with SS_n=1 and SCLK=0 → MISO=0, chnnl_cur=0, res_cur=0, no pulses; the first frame (cmd 0x0000) returns 0x0000 on MISO.
2. ana_vals ch3=0xABC; send frame 0x1800, then frame 0x1800 → first frame: frm_done, chnnl_cur=3, res_cur=0xABC; second frame: MISO bits = 0x0ABC.
3. After the ch3 command, change ch3 to 0x123 before the next frame → MISO still returns 0x0ABC.
4. Send a 10-SCLK frame, then a 17-SCLK frame, then cmd 0xC000 → frm_err pulses three times; chnnl_cur/res_cur unchanged; no frm_done.
5. Assert rst mid-frame with SS_n low, release while SS_n is still low, and continue 8 SCLKs → no pulses; after SS_n goes high, frame 0x3800 with ch7=0xFFF → frm_done, res_cur=0xFFF.
6. Channel sweep k=0..7 with ch k = 0x100·k+k, using back-to-back frames with 4-clk SS_n gaps → frame k+1 returns the value of ch k on MISO.
